wash_sequencer: RTL and testbench

Program sequencer for the washing-machine controller. Converts the selected wash mode into a fixed list of timed phases, advances through them on the 1 s tick, and drives the valve and motor enables. Also publishes total and phase remaining-time counters for the seven-segment display block and raises the completion alarm. It sits between the front-panel debounce/edge logic (which supplies one-cycle pulses) and the display/indicator logic.

---
 rtl/wash_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_wash_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: walks a per-mode ROM of timed phases on the
// 1 s tick, drives valve/motor enables and publishes remaining-time counters.
module wash_sequencer #(
    parameter int FILL_T  = 3,
    parameter int WASH_T  = 9,
    parameter int DRAIN_T = 3,
    parameter int RINSE_T = 9,
    parameter int SPIN_T  = 3,
    parameter int ALARM_T = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       mode_next,
    input  logic       start_pause,
    output logic [2:0] mode,
    output logic [2:0] phase,
    output logic [5:0] total_left,
    output logic [4:0] phase_left,
    output logic       inlet,
    output logic       outlet,
    output logic       motor_wash,
    output logic       motor_rinse,
    output logic       motor_spin,
    output logic       running,
    output logic       alarm
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam logic [2:0] PH_NONE  = 3'd0;
    localparam logic [2:0] PH_FILL  = 3'd1;
    localparam logic [2:0] PH_WASH  = 3'd2;
    localparam logic [2:0] PH_DRAIN = 3'd3;
    localparam logic [2:0] PH_RINSE = 3'd4;
    localparam logic [2:0] PH_SPIN  = 3'd5;

    localparam int AW = $clog2(ALARM_T + 1);

    // Step list per mode, 8 slots each, indexed by {mode, step}; 0 is the end marker.
    // NOTE: this is a constant table, not a register file, so it needs no reset.
    localparam logic [2:0] STEP_ROM [64] = '{
        3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd3, 3'd5, 3'd0,  // 0 standard: W R S
        3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,  // 1 wash: W
        3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd0, 3'd0, 3'd0,  // 2 wash+rinse: W R
        3'd3, 3'd1, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,  // 3 rinse: R
        3'd3, 3'd1, 3'd4, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0,  // 4 rinse+spin: R S
        3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,  // 5 spin: S
        3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
        3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0
    };

    function automatic logic [2:0] rom_phase(input logic [2:0] m, input logic [2:0] s);
        return STEP_ROM[{m, s}];
    endfunction

    function automatic logic [4:0] phase_len(input logic [2:0] p);
        case (p)
            PH_FILL:  return 5'(FILL_T);
            PH_WASH:  return 5'(WASH_T);
            PH_DRAIN: return 5'(DRAIN_T);
            PH_RINSE: return 5'(RINSE_T);
            PH_SPIN:  return 5'(SPIN_T);
            default:  return 5'd0;
        endcase
    endfunction

    function automatic logic [5:0] mode_total(input logic [2:0] m);
        logic [5:0] sum;
        sum = 6'd0;
        for (int s = 0; s < 8; s++) begin
            sum = sum + {1'b0, phase_len(rom_phase(m, 3'(s)))};
        end
        return sum;
    endfunction

    state_t         state_q, state_d;
    logic [2:0]     mode_d, step_q, step_d, phase_d, next_ph;
    logic [5:0]     total_d;
    logic [4:0]     plen_d;
    logic [AW-1:0]  acnt_q, acnt_d;
    logic           reload;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode       <= 3'd0;
            step_q     <= 3'd0;
            phase      <= rom_phase(3'd0, 3'd0);
            phase_left <= phase_len(rom_phase(3'd0, 3'd0));
            total_left <= mode_total(3'd0);
            acnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode       <= mode_d;
            step_q     <= step_d;
            phase      <= phase_d;
            phase_left <= plen_d;
            total_left <= total_d;
            acnt_q     <= acnt_d;
        end
    end

    // NOTE: every variable gets its hold value first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        mode_d  = mode;
        step_d  = step_q;
        phase_d = phase;
        plen_d  = phase_left;
        total_d = total_left;
        acnt_d  = acnt_q;
        reload  = 1'b0;
        next_ph = rom_phase(mode, step_q + 3'd1);

        case (state_q)
            S_IDLE: begin
                if (mode_next) begin
                    mode_d = (mode == 3'd5) ? 3'd0 : mode + 3'd1;
                    reload = 1'b1;
                end
                if (start_pause) state_d = S_RUN;
            end
            S_RUN: begin
                // A simultaneous tick is dropped so the pause freezes the pre-tick counts.
                if (start_pause) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    total_d = total_left - 6'd1;
                    if (phase_left == 5'd1) begin
                        step_d = step_q + 3'd1;
                        if (next_ph == PH_NONE) begin
                            state_d = S_DONE;
                            phase_d = PH_NONE;
                            plen_d  = 5'd0;
                            total_d = 6'd0;
                            acnt_d  = '0;
                        end else begin
                            phase_d = next_ph;
                            plen_d  = phase_len(next_ph);
                        end
                    end else begin
                        plen_d = phase_left - 5'd1;
                    end
                end
            end
            S_PAUSE: begin
                if (start_pause) state_d = S_RUN;
            end
            S_DONE: begin
                if (start_pause) begin
                    state_d = S_IDLE;
                    reload  = 1'b1;
                end else if (tick) begin
                    if (acnt_q == AW'(ALARM_T - 1)) begin
                        state_d = S_IDLE;
                        reload  = 1'b1;
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (reload) begin
            step_d  = 3'd0;
            phase_d = rom_phase(mode_d, 3'd0);
            plen_d  = phase_len(phase_d);
            total_d = mode_total(mode_d);
        end
    end

    assign running     = (state_q == S_RUN);
    assign alarm       = (state_q == S_DONE);
    assign inlet       = running && (phase == PH_FILL);
    assign motor_wash  = running && (phase == PH_WASH);
    assign motor_rinse = running && (phase == PH_RINSE);
    assign outlet      = running && (phase == PH_DRAIN || phase == PH_SPIN);
    assign motor_spin  = running && (phase == PH_SPIN);

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed self-checking bench for wash_sequencer with hand-computed expectations.
module tb_wash_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick, mode_next, start_pause;
    logic [2:0] mode, phase;
    logic [5:0] total_left;
    logic [4:0] phase_left;
    logic       inlet, outlet, motor_wash, motor_rinse, motor_spin, running, alarm;

    int total = 0;
    int bad   = 0;

    wash_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .mode_next(mode_next),
        .start_pause(start_pause), .mode(mode), .phase(phase),
        .total_left(total_left), .phase_left(phase_left), .inlet(inlet),
        .outlet(outlet), .motor_wash(motor_wash), .motor_rinse(motor_rinse),
        .motor_spin(motor_spin), .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic cyc(input logic t, input logic m, input logic s);
        @(negedge clk);
        tick = t; mode_next = m; start_pause = s;
        @(posedge clk);
        #1;
        tick = 1'b0; mode_next = 1'b0; start_pause = 1'b0;
    endtask

    // Standard program: phase and phase end after k ticks, hand-derived.
    int std_end [7] = '{3, 12, 15, 18, 27, 30, 33};
    int std_ph  [7] = '{1, 2, 3, 1, 4, 3, 5};
    int mode_tot [6] = '{33, 12, 27, 15, 21, 6};

    initial begin
        int e_ph, e_pl, idx;
        rst = 1'b1; tick = 1'b0; mode_next = 1'b0; start_pause = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_mode", mode, 0);
        check("rst_phase", phase, 1);
        check("rst_total", total_left, 33);
        check("rst_plen", phase_left, 3);
        check("rst_running", running, 0);
        check("rst_alarm", alarm, 0);
        check("rst_act", {inlet, outlet, motor_wash, motor_rinse, motor_spin}, 0);

        // Mode stepping wraps 5 -> 0; tick alongside mode_next is harmless in IDLE.
        for (int i = 1; i <= 7; i++) begin
            cyc(i == 3, 1'b1, 1'b0);
            check("mode_step", mode, i % 6);
            check("mode_total", total_left, mode_tot[i % 6]);
        end
        check("mode3_plen_after", phase_left, 3);
        repeat (5) cyc(1'b0, 1'b1, 1'b0);
        check("back_to_mode0", mode, 0);

        // Full standard program.
        cyc(1'b0, 1'b0, 1'b1);
        check("start_running", running, 1);
        for (int k = 0; k < 33; k++) begin
            idx = 0;
            while (k >= std_end[idx]) idx++;
            e_ph = std_ph[idx];
            e_pl = std_end[idx] - k;
            check("std_phase", phase, e_ph);
            check("std_plen", phase_left, e_pl);
            check("std_total", total_left, 33 - k);
            check("std_inlet", inlet, (k < 3) || (k >= 15 && k < 18));
            check("std_spin", motor_spin, k >= 30);
            cyc(1'b1, 1'b0, 1'b0);
        end
        check("done_alarm", alarm, 1);
        check("done_phase", phase, 0);
        check("done_total", total_left, 0);
        check("done_running", running, 0);
        check("done_outlet", outlet, 0);
        repeat (9) cyc(1'b1, 1'b0, 1'b0);
        check("alarm_9", alarm, 1);
        cyc(1'b1, 1'b0, 1'b0);
        check("alarm_10", alarm, 0);
        check("idle_total", total_left, 33);
        check("idle_phase", phase, 1);
        check("idle_running", running, 0);

        // Spin mode with pause/resume.
        repeat (5) cyc(1'b0, 1'b1, 1'b0);
        check("mode5", mode, 5);
        check("mode5_total", total_left, 6);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check("pause_phase", phase, 3);
        check("pause_plen", phase_left, 1);
        check("pause_total", total_left, 4);
        check("pause_outlet", outlet, 0);
        repeat (5) cyc(1'b1, 1'b1, 1'b0);
        check("frozen_plen", phase_left, 1);
        check("frozen_total", total_left, 4);
        check("frozen_mode", mode, 5);
        cyc(1'b1, 1'b0, 1'b1);
        check("resume_tick_drop_plen", phase_left, 1);
        check("resume_tick_drop_total", total_left, 4);
        check("resume_outlet", outlet, 1);
        cyc(1'b1, 1'b0, 1'b0);
        check("spin_phase", phase, 5);
        check("spin_plen", phase_left, 3);
        check("spin_total", total_left, 3);
        check("spin_motor", motor_spin, 1);
        cyc(1'b1, 1'b0, 1'b1);
        check("pause_tick_drop_running", running, 0);
        check("pause_tick_drop_plen", phase_left, 3);
        check("pause_tick_drop_total", total_left, 3);
        check("pause_spin_off", motor_spin, 0);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        check("spin_done_alarm", alarm, 1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        check("ack_alarm", alarm, 0);
        check("ack_running", running, 0);
        check("ack_total", total_left, 6);
        check("ack_phase", phase, 3);

        // Wash+rinse into WASH, then mode_next ignored and async reset.
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        check("mode2", mode, 2);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        check("wash_motor", motor_wash, 1);
        cyc(1'b0, 1'b1, 1'b0);
        check("run_mode_hold", mode, 2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_wash_off", motor_wash, 0);
        check("async_mode", mode, 0);
        check("async_total", total_left, 33);
        check("async_running", running, 0);
        #1 rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
